// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR) with ARM-style carry-out,
// valid/ready handshake on both sides and an opaque tag carried with each operation.
module shifter_pipe #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned TAG_W = 4,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_sh,
    input  logic             in_en,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    // Stage 1 handles the low LO_W shift-amount bits, stage 2 the remaining HI_W bits.
    localparam int unsigned LO_W = (SHW + 1) / 2;
    localparam int unsigned HI_W = SHW - LO_W;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Shift d by amt according to the shift type; amt == 0 returns d for every type.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       sh,
        input logic [SHW-1:0]   amt
    );
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   res;
        dbl = {d, d} >> amt;
        case (sh)
            SH_LSL:  res = d << amt;
            SH_LSR:  res = d >> amt;
            SH_ASR:  res = WIDTH'($signed(d) >>> amt);
            default: res = dbl[WIDTH-1:0];
        endcase
        return res;
    endfunction

    // Stage registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [HI_W-1:0]  s1_shamt_hi;
    logic [1:0]       s1_sh;
    logic             s1_en;
    logic             s1_carry;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic             s2_carry;
    logic [TAG_W-1:0] s2_tag;

    // Handshake / stage-1 combinational signals
    logic             adv1;
    logic             adv2;
    logic [SHW-1:0]   lo_amt;
    logic [SHW-1:0]   lsl_idx;
    logic [SHW-1:0]   rsh_idx;
    logic             carry_c;
    logic [WIDTH-1:0] s1_next_data;
    logic [SHW-1:0]   hi_amt;
    logic [WIDTH-1:0] s2_next_data;

    // Pipeline advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv2 = !s2_valid || out_ready;
        adv1 = !s1_valid || adv2;
    end

    assign in_ready = adv1;

    // Stage-1 datapath: low-part shift and carry-out from the original operand.
    always_comb begin
        lo_amt       = '0;
        lsl_idx      = SHW'(0) - in_shamt;
        rsh_idx      = in_shamt - SHW'(1);
        carry_c      = in_carry;
        if (in_en) begin
            lo_amt = SHW'(in_shamt[LO_W-1:0]);
        end
        if (in_en && (in_shamt != '0)) begin
            if (in_sh == SH_LSL) begin
                carry_c = in_data[lsl_idx];
            end else begin
                carry_c = in_data[rsh_idx];
            end
        end
        s1_next_data = shift_by(in_data, in_sh, lo_amt);
    end

    // Stage-2 datapath: shift by the high shift-amount bits carried from stage 1.
    always_comb begin
        hi_amt = '0;
        if (s1_en) begin
            hi_amt = {s1_shamt_hi, LO_W'(0)};
        end
        s2_next_data = shift_by(s1_data, s1_sh, hi_amt);
    end

    // Stage-1 register: captures the input whenever the stage may advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_shamt_hi <= '0;
            s1_sh       <= '0;
            s1_en       <= 1'b0;
            s1_carry    <= 1'b0;
            s1_tag      <= '0;
        end else if (adv1) begin
            s1_valid    <= in_valid;
            s1_data     <= s1_next_data;
            s1_shamt_hi <= in_shamt[SHW-1:LO_W];
            s1_sh       <= in_sh;
            s1_en       <= in_en;
            s1_carry    <= carry_c;
            s1_tag      <= in_tag;
        end
    end

    // Stage-2 register: holds the result stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_carry <= 1'b0;
            s2_tag   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            s2_data  <= s2_next_data;
            s2_carry <= s1_carry;
            s2_tag   <= s1_tag;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_carry = s2_carry;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and scoreboard checks for shifter_pipe: latency, bypass, boundary shifts,
// stall/backpressure ordering, streaming throughput and reset mid-flight.
module tb_shifter_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned SHW   = 5;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_sh;
    logic             in_en;
    logic             in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_sh     (in_sh),
        .in_en     (in_en),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  sh;
        logic        en;
        logic        cin;
        logic [31:0] ed;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [31:0] ed;
        logic        ec;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vt[17];

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int n_acc     = 0;
    int pops      = 0;
    int first_pop = -1;
    int last_pop  = -1;

    // Single comparison point: counts and reports every check.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic [4:0] s, input logic [1:0] sh,
                                input logic en, input logic cin, input logic [31:0] ed,
                                input logic ec);
        vec_t v;
        v.d = d; v.s = s; v.sh = sh; v.en = en; v.cin = cin; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    // Bit-by-bit reference model used for the random streaming ops.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   s;
        r = v;
        s = v.en ? int'(v.s) : 0;
        for (int i = 0; i < 32; i++) begin
            case (v.sh)
                2'b00:   r.ed[i] = (i >= s) ? v.d[i - s] : 1'b0;
                2'b01:   r.ed[i] = (i + s < 32) ? v.d[i + s] : 1'b0;
                2'b10:   r.ed[i] = (i + s < 32) ? v.d[i + s] : v.d[31];
                default: r.ed[i] = v.d[(i + s) % 32];
            endcase
        end
        if (s == 0)            r.ec = v.cin;
        else if (v.sh == 2'b00) r.ec = v.d[32 - s];
        else                   r.ec = v.d[s - 1];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every output transfer is checked against the scoreboard in order.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_tag", 32'(out_tag), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data, mon_e.ed);
                chk("out_carry", 32'(out_carry), 32'(mon_e.ec));
                chk("out_tag", 32'(out_tag), 32'(mon_e.tag));
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
    end

    // Present one op and hold it until accepted (bounded).
    task automatic send(input vec_t v, input logic [3:0] tag);
        bit   done;
        exp_t e;
        done     = 1'b0;
        in_data  = v.d;
        in_shamt = v.s;
        in_sh    = v.sh;
        in_en    = v.en;
        in_carry = v.cin;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.ed = v.ed; e.ec = v.ec; e.tag = tag;
                exp_q.push_back(e);
                n_acc++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc0;
        int   seen;
        vec_t v;

        vt[0]  = mk(32'h0000_00F1, 5'd4,  2'b00, 1'b1, 1'b0, 32'h0000_0F10, 1'b0);
        vt[1]  = mk(32'h8000_0001, 5'd1,  2'b10, 1'b1, 1'b0, 32'hC000_0000, 1'b1);
        vt[2]  = mk(32'h8000_0001, 5'd4,  2'b11, 1'b1, 1'b1, 32'h1800_0000, 1'b0);
        vt[3]  = mk(32'hDEAD_BEEF, 5'd7,  2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[4]  = mk(32'hDEAD_BEEF, 5'd9,  2'b01, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[5]  = mk(32'hDEAD_BEEF, 5'd9,  2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[6]  = mk(32'hDEAD_BEEF, 5'd9,  2'b11, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[7]  = mk(32'hDEAD_BEEF, 5'd0,  2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[8]  = mk(32'hDEAD_BEEF, 5'd0,  2'b01, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[9]  = mk(32'hDEAD_BEEF, 5'd0,  2'b10, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[10] = mk(32'hDEAD_BEEF, 5'd0,  2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        vt[11] = mk(32'h8000_0000, 5'd31, 2'b01, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
        vt[12] = mk(32'h0000_0003, 5'd31, 2'b00, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
        vt[13] = mk(32'h8000_0000, 5'd31, 2'b10, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        vt[14] = mk(32'h1234_5678, 5'd8,  2'b11, 1'b1, 1'b0, 32'h7812_3456, 1'b0);
        vt[15] = mk(32'h0000_00F0, 5'd5,  2'b01, 1'b1, 1'b0, 32'h0000_0007, 1'b1);
        vt[16] = mk(32'h1234_5678, 5'd31, 2'b11, 1'b1, 1'b1, 32'h2468_ACF0, 1'b0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_sh     = '0;
        in_en     = 1'b0;
        in_carry  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_out_tag",   32'(out_tag), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Directed single ops with 2-cycle latency check
        for (int i = 0; i < 17; i++) begin
            send(vt[i], 4'(i));
            @(negedge clk);
            chk("lat1_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("lat2_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        drain("directed_drain");

        // Backpressure: 4 ops, out_ready low for 5 cycles
        out_ready = 1'b0;
        acc0      = n_acc;
        fork
            begin
                for (int i = 0; i < 4; i++) send(vt[i], 4'(i + 1));
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    #1;
                    if (c >= 2) begin
                        chk("stall_in_ready",  32'(in_ready), 32'd0);
                        chk("stall_out_valid", 32'(out_valid), 32'd1);
                        chk("stall_out_tag",   32'(out_tag), 32'd1);
                        chk("stall_out_data",  out_data, 32'h0000_0F10);
                        chk("stall_out_carry", 32'(out_carry), 32'd0);
                    end
                end
                chk("stall_accepts", 32'(n_acc - acc0), 32'd2);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Streaming: 16 random ops back-to-back with out_ready high
        pops      = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int i = 0; i < 16; i++) begin
            v.d   = $urandom;
            v.s   = 5'($urandom_range(0, 31));
            v.sh  = 2'($urandom_range(0, 3));
            v.en  = ($urandom_range(0, 7) != 0);
            v.cin = 1'($urandom_range(0, 1));
            v     = model(v);
            send(v, 4'(i));
        end
        drain("stream_drain");
        chk("stream_count", 32'(pops), 32'd16);
        chk("stream_span", 32'(last_pop - first_pop), 32'd15);

        // Reset with both stages full
        out_ready = 1'b0;
        send(vt[14], 4'hA);
        send(vt[15], 4'hB);
        @(negedge clk);
        chk("prerst_out_valid", 32'(out_valid), 32'd1);
        chk("prerst_in_ready",  32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready), 32'd1);
        chk("midrst_out_data",  out_data, 32'd0);
        chk("midrst_out_carry", 32'(out_carry), 32'd0);
        chk("midrst_out_tag",   32'(out_tag), 32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_ghost", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
